// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multicycle controller sequencing the registered barrel shifter
// Walks the shifter through load, shift and capture, then presents a registered result with a done pulse.
module shift_sequencer #(
    parameter int SHIFT_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    input  logic [2:0]         op,
    input  logic               amt_sel,
    input  logic [SHIFT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  rs_amt,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [DATA_W-1:0]  shifter_out,
    output logic [2:0]         shifter_ctrl,
    output logic [SHIFT_W-1:0] shifter_n,
    output logic [DATA_W-1:0]  shifter_data,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [2:0] CTRL_NOP  = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b001;

    state_t             state;
    logic [2:0]         op_q;
    logic [SHIFT_W-1:0] amt_q;

    logic               op_legal;
    logic [SHIFT_W-1:0] req_amt;
    logic               rs_amt_unused;

    assign op_legal      = (op <= 3'b100);
    // Register amounts are truncated to the shift width, so 32 acts as 0.
    assign req_amt       = amt_sel ? rs_amt[SHIFT_W-1:0] : shamt;
    assign rs_amt_unused = ^rs_amt[DATA_W-1:SHIFT_W];

    function automatic logic [2:0] map_op(input logic [2:0] o);
        case (o)
            3'b000:  map_op = 3'b010;
            3'b001:  map_op = 3'b011;
            3'b010:  map_op = 3'b100;
            3'b011:  map_op = 3'b101;
            3'b100:  map_op = 3'b110;
            default: map_op = CTRL_NOP;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= '0;
            amt_q        <= '0;
            shifter_ctrl <= CTRL_NOP;
            shifter_n    <= '0;
            shifter_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            error        <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    shifter_ctrl <= CTRL_NOP;
                    shifter_n    <= '0;
                    if (start && !flush) begin
                        if (op_legal) begin
                            op_q         <= op;
                            amt_q        <= req_amt;
                            shifter_data <= data_in;
                            shifter_ctrl <= CTRL_LOAD;
                            busy         <= 1'b1;
                            state        <= LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (flush) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        shifter_ctrl <= CTRL_NOP;
                    end else if (amt_q != '0) begin
                        state        <= SHIFT;
                        shifter_ctrl <= map_op(op_q);
                        shifter_n    <= amt_q;
                    end else begin
                        // Zero shift: the loaded value is already the answer.
                        state        <= CAPTURE;
                        shifter_ctrl <= CTRL_NOP;
                    end
                end
                SHIFT: begin
                    shifter_ctrl <= CTRL_NOP;
                    shifter_n    <= '0;
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    shifter_ctrl <= CTRL_NOP;
                    busy         <= 1'b0;
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= shifter_out;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    shifter_ctrl <= CTRL_NOP;
                    shifter_n    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
// A behavioural registered shifter closes the loop; results are scoreboarded against a reference shift model.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic        amt_sel;
    logic [4:0]  shamt;
    logic [31:0] rs_amt;
    logic [31:0] data_in;
    logic [31:0] shifter_out;
    logic [2:0]  shifter_ctrl;
    logic [4:0]  shifter_n;
    logic [31:0] shifter_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        error;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    shift_sequencer #(.SHIFT_W(5), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .amt_sel      (amt_sel),
        .shamt        (shamt),
        .rs_amt       (rs_amt),
        .data_in      (data_in),
        .shifter_out  (shifter_out),
        .shifter_ctrl (shifter_ctrl),
        .shifter_n    (shifter_n),
        .shifter_data (shifter_data),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered shifter standing in for RegDesloc.
    always @(posedge clk) begin
        if (reset) shifter_out <= 32'h0;
        else begin
            case (shifter_ctrl)
                3'b001: shifter_out <= shifter_data;
                3'b010: shifter_out <= shifter_out << shifter_n;
                3'b011: shifter_out <= shifter_out >> shifter_n;
                3'b100: shifter_out <= $signed(shifter_out) >>> shifter_n;
                3'b101: shifter_out <= (shifter_out >> shifter_n) | (shifter_out << (6'd32 - shifter_n));
                3'b110: shifter_out <= (shifter_out << shifter_n) | (shifter_out >> (6'd32 - shifter_n));
                default: shifter_out <= shifter_out;
            endcase
        end
    end

    function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] a, input logic [31:0] d);
        logic [63:0] dd;
        dd = {d, d};
        case (o)
            3'b000:  model = d << a;
            3'b001:  model = d >> a;
            3'b010:  model = $signed(d) >>> a;
            3'b011:  model = dd[a +: 32];
            3'b100:  model = dd[(6'd32 - {1'b0, a}) % 32 +: 32];
            default: model = 32'hx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic sel, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] d, input bit push);
        op      = o;
        amt_sel = sel;
        shamt   = sh;
        rs_amt  = rs;
        data_in = d;
        start   = 1'b1;
        if (push) exp_q.push_back(model(o, sel ? rs[4:0] : sh, d));
        tick();
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~sh;
        rs_amt  = ~rs;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_done observed=%h expected=none", result);
                end
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("scoreboard_result", result, e);
                end
            end
            if (done || error) chk("done_error_exclusive", {31'h0, done & error}, 32'h0);
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b0; amt_sel = 1'b0;
        shamt = 5'h0; rs_amt = 32'h0; data_in = 32'h0;
        tick(); tick();
        chk("rst_ctrl", {29'h0, shifter_ctrl}, 32'h0);
        chk("rst_n", {27'h0, shifter_n}, 32'h0);
        chk("rst_data", shifter_data, 32'h0);
        chk("rst_flags", {29'h0, busy, done, error}, 32'h0);
        chk("rst_result", result, 32'h0);
        reset = 1'b0;
        tick();

        // sll 4 of 1, walking every state
        issue(3'b000, 1'b0, 5'd4, 32'h0, 32'h0000_0001, 1'b1);
        chk("sll_load_ctrl", {29'h0, shifter_ctrl}, 32'h1);
        chk("sll_load_data", shifter_data, 32'h1);
        chk("sll_load_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("sll_shift_ctrl", {29'h0, shifter_ctrl}, 32'h2);
        chk("sll_shift_n", {27'h0, shifter_n}, 32'h4);
        tick();
        chk("sll_capture_ctrl", {29'h0, shifter_ctrl}, 32'h0);
        chk("sll_capture_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("sll_done", {30'h0, done, busy}, 32'h2);
        chk("sll_result", result, 32'h0000_0010);
        tick();
        chk("sll_done_pulse", {31'h0, done}, 32'h0);

        // sra / srl by 31 from a register amount
        issue(3'b010, 1'b1, 5'd0, 32'h0000_003F, 32'h8000_0000, 1'b1);
        wait_done("sra");
        chk("sra_result", result, 32'hFFFF_FFFF);
        tick();
        issue(3'b001, 1'b1, 5'd0, 32'h0000_003F, 32'h8000_0000, 1'b1);
        wait_done("srl");
        chk("srl_result", result, 32'h0000_0001);
        tick();

        // rs_amt 32 truncates to 0: zero-shift fast path
        issue(3'b001, 1'b1, 5'd0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1);
        chk("zero_load_ctrl", {29'h0, shifter_ctrl}, 32'h1);
        tick();
        chk("zero_capture", {28'h0, shifter_ctrl, busy}, 32'h1);
        tick();
        chk("zero_done", {31'h0, done}, 32'h1);
        chk("zero_result", result, 32'hDEAD_BEEF);
        tick();

        // illegal op
        issue(3'b111, 1'b0, 5'd3, 32'h0, 32'h5, 1'b0);
        chk("illegal_error", {31'h0, error}, 32'h1);
        chk("illegal_idle", {28'h0, shifter_ctrl, busy}, 32'h0);
        tick();
        chk("illegal_pulse", {30'h0, error, done}, 32'h0);
        chk("illegal_idle2", {28'h0, shifter_ctrl, busy}, 32'h0);

        // back-to-back ror then rol, with an ignored start while busy
        issue(3'b011, 1'b0, 5'd8, 32'h0, 32'h1234_5678, 1'b1);
        op = 3'b000; data_in = 32'hFFFF_FFFF; shamt = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ror");
        chk("ror_result", result, 32'h7812_3456);
        issue(3'b100, 1'b0, 5'd4, 32'h0, 32'h1234_5678, 1'b1);
        chk("b2b_no_bubble", {28'h0, shifter_ctrl, busy}, 32'h3);
        wait_done("rol");
        chk("rol_result", result, 32'h2345_6781);
        tick();

        // flush during SHIFT
        issue(3'b000, 1'b0, 5'd3, 32'h0, 32'h7, 1'b0);
        tick();
        chk("flush_pre_ctrl", {29'h0, shifter_ctrl}, 32'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {27'h0, shifter_ctrl, busy, done}, 32'h0);
        repeat (6) tick();
        chk("flush_result_held", result, 32'h2345_6781);

        // reset during SHIFT
        issue(3'b000, 1'b0, 5'd3, 32'h0, 32'h7, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid_idle", {27'h0, shifter_ctrl, busy, done}, 32'h0);
        chk("reset_mid_result", result, 32'h0);
        repeat (5) tick();

        // simultaneous start and flush: request dropped
        op = 3'b000; amt_sel = 1'b0; shamt = 5'd2; data_in = 32'h1; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("start_flush_dropped", {28'h0, shifter_ctrl, busy}, 32'h0);
        repeat (6) tick();

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle controller that sequences the registered barrel shifter (RegDesloc) in the logic unit for the SLL/SRL/SRA/SLLV/SRLV/SRAV instruction family, plus rotates.
- Sits between the main control unit and the shifter.
- Accepts a one-cycle start request, then drives shifter control through load, shift and capture.
- Returns a registered result with a one-cycle done pulse; the control unit stalls on busy.

Parameters:
- SHIFT_W, 5, width of the shift amount (log2 of the data width).
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE or DONE.
- flush  in  1  synchronous abort; returns to IDLE without done.
- op  in  3  000 sll, 001 srl, 010 sra, 011 ror, 100 rol, 101-111 illegal.
- amt_sel  in  1  0: use shamt; 1: use rs_amt[4:0].
- shamt  in  5  immediate shift amount (instruction bits 10:6).
- rs_amt  in  32  register-sourced amount; bits 31:5 ignored.
- data_in  in  32  value to shift (rt operand).
- shifter_out  in  32  shifter register output.
- shifter_ctrl  out  3  shifter op: 000 nop, 001 load, 010 sll, 011 srl, 100 sra, 101 ror, 110 rol.
- shifter_n  out  5  shifter amount.
- shifter_data  out  32  shifter load data.
- busy  out  1  high in LOAD, SHIFT and CAPTURE.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  registered shift result; held until the next capture.
- error  out  1  one-cycle pulse on an illegal op.

Behaviour:
- Reset (sync, active high, overrides start and flush):
  - state=IDLE.
  - shifter_ctrl=000, shifter_n=0, shifter_data=0.
  - busy=0, done=0, error=0, result=0.
  - All internal latches cleared.
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE. All outputs are registered or decoded from state plus latched request; no combinational path from start to shifter_ctrl.
- IDLE, start=1, legal op:
  - Latch op, data_in, and amt = amt_sel ? rs_amt[4:0] : shamt.
  - Go to LOAD.
- IDLE, start=1, illegal op:
  - Stay IDLE; error=1 next cycle for exactly one cycle.
  - No shifter activity, no done.
- LOAD: shifter_ctrl=001, shifter_data=latched data.
  - If amt≠0, next state is SHIFT; if amt=0, next state is CAPTURE (zero-shift fast path).
- SHIFT: shifter_ctrl = mapped op code, shifter_n=amt. Next state CAPTURE.
- CAPTURE: shifter_ctrl=000; result <= shifter_out at the end of the cycle. Next state DONE.
- DONE: done=1, busy=0, result valid.
  - start=1 with a legal op: latch the new request, go to LOAD (back-to-back, no IDLE bubble).
  - start=1 with an illegal op: error pulse next cycle, go to IDLE.
  - Otherwise go to IDLE.
- Latency, from the edge sampling start to the cycle done is high:
  - 4 cycles for amt≠0.
  - 3 cycles for amt=0.
  - Throughput is one op per 4 cycles (3 for zero shifts).
- start while busy: ignored, with no queueing and no error.
- Input changes after acceptance have no effect on the operation in flight.
- flush in LOAD, SHIFT or CAPTURE:
  - Next state IDLE; shifter_ctrl=000 next cycle.
  - result unchanged, no done pulse.
  - flush in IDLE or DONE only suppresses a simultaneous start.
- Simultaneous start and flush: flush wins; the request is dropped.
- Reset mid-operation: immediate return to IDLE with all reset values.
- Amount width: rs_amt is truncated to 5 bits, so 32 behaves as 0 and 33 as 1 (MIPS semantics).
- Shifter response: the sequencer relies on the shifter updating on the clock edge ending each cycle in which the control is applied.
- error and done are never high in the same cycle.

Test Plan:
- sll, amt_sel=0, shamt=4, data_in=0x0000_0001 -> busy for 3 cycles; done in cycle 4; result=0x0000_0010; shifter_ctrl sequence 001,010,000.
- sra, amt_sel=1, rs_amt=0x0000_003F (amt 31), data_in=0x8000_0000 -> result=0xFFFF_FFFF; srl with the same inputs -> result=0x0000_0001.
- srl, rs_amt=0x0000_0020 (amt 0), data_in=0xDEAD_BEEF -> no SHIFT state; done in cycle 3; result=0xDEAD_BEEF.
- op=111 in IDLE -> error pulse for one cycle; shifter_ctrl stays 000; no done; busy stays 0.
- Back-to-back: start ror amt 8 on 0x1234_5678, then start rol amt 4 on 0x1234_5678 in the DONE cycle -> results 0x7812_3456, then 0x2345_6781; no IDLE bubble between the two; a start while busy is ignored.
- Start sll amt 3, then assert reset (or flush) during SHIFT -> next cycle IDLE, shifter_ctrl=000, no done; result=0 after reset, or unchanged after flush.
